// File: rtl/uplus_40g_pkg.sv
// Shared types and helpers for the 40G TX arbiter and RX demux.
// Holds the arbiter state encoding and the compile-time sizing functions.
package uplus_40g_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned beat_limit(
    input int unsigned len,
    input int unsigned bpb
  );
    return (len + bpb - 1) / bpb;
  endfunction

endpackage

// File: rtl/uplus_rr_picker.sv
// Combinational round-robin picker: first requester after last_i wins.
// Produces a one-hot grant, its index and an any-request flag.
module uplus_rr_picker
  import uplus_40g_pkg::*;
#(
  parameter int P_PORTS = 4,
  parameter int IDX_W   = clog2(P_PORTS)
) (
  input  logic [P_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [P_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int k;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = P_PORTS; i >= 1; i--) begin
      k = int'(last_i) + i;
      if (k >= P_PORTS) k = k - P_PORTS;
      if (req_i[IDX_W'(k)]) begin
        gnt_o = '0;
        gnt_o[IDX_W'(k)] = 1'b1;
        idx_o = IDX_W'(k);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uplus_40g_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the 40G channel TX AXI-Stream.
// Gates new packets on link status and truncates runaway packets.
module uplus_40g_tx_arbiter
  import uplus_40g_pkg::*;
#(
  parameter int P_PORTS      = 4,
  parameter int P_DATA_W     = 256,
  parameter int P_MAX_LENGTH = 9600
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_link_up,
  input  logic [P_PORTS-1:0]            s_axis_tvalid,
  output logic [P_PORTS-1:0]            s_axis_tready,
  input  logic [P_PORTS*P_DATA_W-1:0]   s_axis_tdata,
  input  logic [P_PORTS*P_DATA_W/8-1:0] s_axis_tkeep,
  input  logic [P_PORTS-1:0]            s_axis_tlast,
  input  logic [P_PORTS-1:0]            s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [P_DATA_W-1:0]           m_axis_tdata,
  output logic [P_DATA_W/8-1:0]         m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [P_PORTS-1:0]            o_grant,
  output logic                          o_trunc_pulse
);

  localparam int KEEP_W = P_DATA_W / 8;
  localparam int IDX_W  = clog2(P_PORTS);
  localparam int L      = beat_limit(P_MAX_LENGTH, KEEP_W);
  localparam int CNT_W  = clog2(L + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  arb_state_e          state_q, state_d;
  logic [P_PORTS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [P_PORTS-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  logic [P_DATA_W-1:0] own_data;
  logic [KEEP_W-1:0]   own_keep;
  logic                own_valid;
  logic                own_last;
  logic                own_user;
  logic                trunc_beat;

  uplus_rr_picker #(
    .P_PORTS(P_PORTS),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i (s_axis_tvalid),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // AND-OR mux on the one-hot grant: all zero when nobody owns the port.
  always_comb begin
    own_data = '0;
    own_keep = '0;
    for (int k = 0; k < P_PORTS; k++) begin
      if (grant_q[k]) begin
        own_data = own_data | s_axis_tdata[k*P_DATA_W +: P_DATA_W];
        own_keep = own_keep | s_axis_tkeep[k*KEEP_W +: KEEP_W];
      end
    end
  end

  assign own_valid  = |(grant_q & s_axis_tvalid);
  assign own_last   = |(grant_q & s_axis_tlast);
  assign own_user   = |(grant_q & s_axis_tuser);
  assign trunc_beat = (cnt_q == CNT_LAST) && !own_last;

  assign m_axis_tdata = own_data;
  assign m_axis_tkeep = own_keep;
  assign o_grant      = grant_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    o_trunc_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_link_up && pick_any) begin
          state_d = ST_XFER;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ST_XFER: begin
        m_axis_tvalid = own_valid;
        m_axis_tlast  = own_last | trunc_beat;
        m_axis_tuser  = own_user | trunc_beat;
        s_axis_tready = grant_q & {P_PORTS{m_axis_tready}};
        if (own_valid && m_axis_tready) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (own_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = owner_q;
            cnt_d   = '0;
          end else if (trunc_beat) begin
            state_d       = ST_DROP;
            o_trunc_pulse = 1'b1;
          end
        end
      end
      ST_DROP: begin
        s_axis_tready = grant_q;
        if (own_valid && own_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(P_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
